// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- load/store bus controller
//
// Sits between the execute-stage memory-operation block and the data-memory
// port. A LOAD or STORE request is registered, then presented on a
// req/gnt/rvalid bus. The pipeline is stalled (busy_o) until the response
// arrives. A load's word is returned on rdata_o. A misaligned address or a
// missing response terminates the access with a done_o + err_o pulse.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   valid_i / ready_o      request handshake from execute (ready only in IDLE)
//   func_i, we_i           operation code (LOAD/STORE acted on), store enable
//   addr_i, wdata_i        byte address (rs1) and store data (rs2)
//   busy_o                 stall while an access is in flight
//   done_o, err_o          one-cycle completion pulse, error qualifier
//   rdata_o                last successfully loaded word
//   mem_req_o, mem_we_o    bus request / write strobe
//   mem_addr_o, mem_wdata_o bus address / write data (hold when idle)
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  bus grant, response, read data
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;
  typedef enum logic [3:0] {
    FUNC_ADD   = 4'd0,
    FUNC_SUB   = 4'd1,
    FUNC_AND   = 4'd2,
    FUNC_OR    = 4'd3,
    FUNC_XOR   = 4'd4,
    FUNC_SLL   = 4'd5,
    FUNC_SRL   = 4'd6,
    FUNC_LOAD  = 4'd7,
    FUNC_STORE = 4'd8
  } func_t;
endpackage

module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  func_t                 func_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]            r_state;
  logic                  r_we;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            w_state_next;
  logic                  w_set_err;
  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic                  w_rsp;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;

  // Only LOAD, or STORE with its write enable set, counts as a request.
  assign w_accept     = valid_i && (r_state == S_IDLE) &&
                        ((func_i == FUNC_LOAD) || ((func_i == FUNC_STORE) && we_i));
  assign w_misaligned = (addr_i[1:0] != 2'b00);

  // The counter is cleared on accept, so after k cycles in REQ/WAIT_RSP it
  // would become k; abort on the edge where it would reach the limit.
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  assign w_timeout = (w_cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

  // A response completes the access; grant and response may coincide in REQ.
  assign w_rsp = ((r_state == S_REQ) && mem_gnt_i && mem_rvalid_i) ||
                 ((r_state == S_WAIT_RSP) && mem_rvalid_i);

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_misaligned ? S_DONE : S_REQ;
          w_set_err    = w_misaligned;
        end
      end
      S_REQ: begin
        if (w_rsp) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_set_err    = 1'b1;
        end else if (mem_gnt_i) begin
          w_state_next = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // A response in the final cycle still wins over the timeout.
        if (w_rsp) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_set_err    = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      // err_o lives only for the single DONE cycle it was set on entry to.
      r_err   <= w_set_err;

      if (w_accept && !w_misaligned) begin
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_we    <= (func_i == FUNC_STORE);
      end

      if (w_accept) begin
        r_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT_RSP)) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_rsp && !r_we) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  assign ready_o     = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = r_we && (r_state == S_REQ);
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl -- scoreboard bench for dmem_ctrl
//
// The stimulus thread issues directed requests and plays the memory side;
// for every access expected to complete it pushes the expected completion
// (error flag, load word, completion cycle) into a queue. A separate monitor
// pops and compares whenever done_o is seen. Bus-side and stall behaviour is
// checked inline by the stimulus thread.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DW = 32;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic          ready_o;
  func_t         func_i;
  logic          we_i;
  logic [DW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;

  dmem_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .func_i      (func_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc;
  exp_t sb[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one edge; acc is the cycle index right after it.
  task automatic issue(input func_t f, input logic we, input logic [DW-1:0] a,
                       input logic [DW-1:0] d);
    valid_i = 1'b1;
    func_i  = f;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    step();
    acc     = cyc;
    valid_i = 1'b0;
  endtask

  task automatic expect_done(input logic err, input logic [DW-1:0] rd, input int offs);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = acc + offs;
    sb.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_err", {31'b0, err_o}, {31'b0, e.err});
        check("done_rdata", rdata_o, e.rdata);
        check("done_cycle", cyc, e.cyc);
      end
    end else if (err_o) begin
      check("err_without_done", {31'b0, err_o}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    func_i       = FUNC_ADD;
    we_i         = 1'b0;
    addr_i       = '0;
    wdata_i      = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    step();
    step();
    check("rst_ready",  {31'b0, ready_o},   32'd1);
    check("rst_busy",   {31'b0, busy_o},    32'd0);
    check("rst_req",    {31'b0, mem_req_o}, 32'd0);
    check("rst_we",     {31'b0, mem_we_o},  32'd0);
    check("rst_rdata",  rdata_o,            32'd0);
    check("rst_addr",   mem_addr_o,         32'd0);
    rst_i = 1'b0;
    step();

    // 1) LOAD with grant in the first REQ cycle and response the next.
    issue(FUNC_LOAD, 1'b0, 32'h0000_0010, 32'h0);
    expect_done(1'b0, 32'hDEAD_BEEF, 2);
    check("ld_req",  {31'b0, mem_req_o}, 32'd1);
    check("ld_addr", mem_addr_o, 32'h0000_0010);
    check("ld_we",   {31'b0, mem_we_o}, 32'd0);
    check("ld_busy", {31'b0, busy_o}, 32'd1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    check("ld_req_dropped", {31'b0, mem_req_o}, 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    step();
    check("ld_rdata_hold", rdata_o, 32'hDEAD_BEEF);
    check("ld_ready",      {31'b0, ready_o}, 32'd1);

    // 2) STORE with grant delayed three cycles; bus must stay stable.
    issue(FUNC_STORE, 1'b1, 32'h0000_0020, 32'h1234_5678);
    expect_done(1'b0, 32'hDEAD_BEEF, 5);
    for (int i = 0; i < 3; i++) begin
      check("st_req",   {31'b0, mem_req_o}, 32'd1);
      check("st_we",    {31'b0, mem_we_o},  32'd1);
      check("st_addr",  mem_addr_o,  32'h0000_0020);
      check("st_wdata", mem_wdata_o, 32'h1234_5678);
      check("st_busy",  {31'b0, busy_o}, 32'd1);
      step();
    end
    check("st_req_last", {31'b0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    check("st_wait_busy", {31'b0, busy_o}, 32'd1);
    step();
    mem_rvalid_i = 1'b0;
    step();
    check("st_rdata_kept", rdata_o, 32'hDEAD_BEEF);

    // 3) Ignored requests: STORE without write enable, then an ALU op.
    issue(FUNC_STORE, 1'b0, 32'h0000_0030, 32'h5555_5555);
    check("ign_st_ready", {31'b0, ready_o},   32'd1);
    check("ign_st_req",   {31'b0, mem_req_o}, 32'd0);
    issue(FUNC_ADD, 1'b1, 32'h0000_0034, 32'h6666_6666);
    check("ign_add_ready", {31'b0, ready_o},   32'd1);
    check("ign_add_req",   {31'b0, mem_req_o}, 32'd0);
    step();
    check("ign_addr_held", mem_addr_o, 32'h0000_0020);

    // 4) Misaligned LOAD: error completion right after accept, no bus request.
    issue(FUNC_LOAD, 1'b0, 32'h0000_0013, 32'h0);
    expect_done(1'b1, 32'hDEAD_BEEF, 0);
    check("mis_req", {31'b0, mem_req_o}, 32'd0);
    step();
    check("mis_ready", {31'b0, ready_o}, 32'd1);
    check("mis_req_after", {31'b0, mem_req_o}, 32'd0);

    // 5) Timeout: grant but no response; 16 cycles in REQ/WAIT_RSP.
    issue(FUNC_LOAD, 1'b0, 32'h0000_0050, 32'h0);
    expect_done(1'b1, 32'hDEAD_BEEF, 16);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    check("to_wait_req", {31'b0, mem_req_o}, 32'd0);
    check("to_wait_busy", {31'b0, busy_o}, 32'd1);
    repeat (15) step();
    // Stray response during DONE and in the following IDLE cycle.
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1111_1111;
    step();
    check("to_ready", {31'b0, ready_o}, 32'd1);
    step();
    mem_rvalid_i = 1'b0;
    check("to_rdata_kept", rdata_o, 32'hDEAD_BEEF);
    check("to_stray_idle", {31'b0, busy_o}, 32'd0);

    // 6) Reset while waiting for a response abandons the access.
    issue(FUNC_LOAD, 1'b0, 32'h0000_0040, 32'h0);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    rst_i     = 1'b1;
    step();
    rst_i = 1'b0;
    check("rr_ready", {31'b0, ready_o},   32'd1);
    check("rr_req",   {31'b0, mem_req_o}, 32'd0);
    check("rr_rdata", rdata_o, 32'd0);
    check("rr_busy",  {31'b0, busy_o}, 32'd0);
    step();

    // Same-cycle grant and response: done the cycle after REQ.
    issue(FUNC_LOAD, 1'b0, 32'h0000_0044, 32'h0);
    expect_done(1'b0, 32'hA5A5_A5A5, 1);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hA5A5_A5A5;
    step();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    step();
    check("fast_rdata", rdata_o, 32'hA5A5_A5A5);
    check("fast_ready", {31'b0, ready_o}, 32'd1);

    repeat (3) step();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
